mem_port_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one 8-input memory-port mux between eight requesters.
- Produces the registered 3-bit mux select and a one-hot grant, and bounds each ownership to MAX_BURST accepted beats.
- Ownership is handed over without a bubble.
- Sits in the MEM stage in front of the 8-to-1 data mux, which it drives directly through Selector.

---
 rtl/mem_port_arbiter_8.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter_8.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_8.sv
// Round-robin arbiter for an 8-input memory-port mux: registered one-hot grant,
// 3-bit mux select, and per-ownership burst limit with bubble-free handover.
module mem_port_arbiter_8 #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_BITS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          Request,
    input  logic                Port_Ready,
    output logic [7:0]          Grant,
    output logic [2:0]          Selector,
    output logic                Grant_Valid,
    output logic [CNT_BITS-1:0] Beat_Count
);

    localparam int unsigned NREQ = 8;
    localparam int unsigned IW   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [IW-1:0]       sel_q, sel_d;
    logic                valid_q, valid_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [IW-1:0]       last_q, last_d;

    logic [NREQ-1:0]     cand;
    logic [IW-1:0]       start;
    logic [IW-1:0]       idx;
    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic                burst_end;
    logic                take;
    logic                drop;

    // Round-robin search from last owner + 1; the current owner is masked out
    always_comb begin
        cand       = Request & ~grant_q;
        start      = last_q + IW'(1);
        idx        = start;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = start + IW'(k);
            if (!pick_found && cand[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    assign burst_end = Port_Ready && (cnt_q == CNT_BITS'(MAX_BURST - 1));

    // Next-state: release beats burst limit beats plain beat counting
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        take    = 1'b0;
        drop    = 1'b0;

        case (state_q)
            IDLE: begin
                take = pick_found;
            end
            BUSY: begin
                if (!Request[sel_q]) begin
                    take = pick_found;
                    drop = !pick_found;
                end else if (burst_end) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end else if (Port_Ready) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            default: begin
                drop = 1'b1;
            end
        endcase

        if (take) begin
            state_d = BUSY;
            grant_d = NREQ'(1) << pick_idx;
            sel_d   = pick_idx;
            valid_d = 1'b1;
            cnt_d   = '0;
            last_d  = pick_idx;
        end else if (drop) begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end
    end

    // Last owner resets to 7 so requester 0 has first priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign Grant       = grant_q;
    assign Selector    = sel_q;
    assign Grant_Valid = valid_q;
    assign Beat_Count  = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter_8.sv
// Directed bench for mem_port_arbiter_8 (MAX_BURST=4): hand-computed grant,
// select, valid and beat-count expectations checked with immediate assertions.
module tb_mem_port_arbiter_8;

    logic       clk;
    logic       reset;
    logic [7:0] Request;
    logic       Port_Ready;
    logic [7:0] Grant;
    logic [2:0] Selector;
    logic       Grant_Valid;
    logic [3:0] Beat_Count;

    int tests;
    int fails;

    mem_port_arbiter_8 #(.MAX_BURST(4), .CNT_BITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Request    (Request),
        .Port_Ready (Port_Ready),
        .Grant      (Grant),
        .Selector   (Selector),
        .Grant_Valid(Grant_Valid),
        .Beat_Count (Beat_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                           input logic v, input logic [3:0] c);
        chk({tag, ".grant"}, 32'(Grant), 32'(g));
        chk({tag, ".sel"},   32'(Selector), 32'(s));
        chk({tag, ".valid"}, 32'(Grant_Valid), 32'(v));
        chk({tag, ".cnt"},   32'(Beat_Count), 32'(c));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b0;
        Request    = 8'h00;
        Port_Ready = 1'b0;

        // 1: reset state, then first grant one cycle after request
        #2;
        chk_all("t1_reset", 8'h00, 3'd0, 1'b0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk_all("t1_idle", 8'h00, 3'd0, 1'b0, 4'd0);
        Request = 8'h01;
        step();
        chk_all("t1_grant", 8'h01, 3'd0, 1'b1, 4'd0);

        // 2: burst-limited rotation between 0 and 7 with wrap-around
        Request    = 8'h81;
        Port_Ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk_all($sformatf("t2_own0_b%0d", i), 8'h01, 3'd0, 1'b1, 4'(i));
        end
        step();
        chk_all("t2_hand7", 8'h80, 3'd7, 1'b1, 4'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk_all($sformatf("t2_own7_b%0d", i), 8'h80, 3'd7, 1'b1, 4'(i));
        end
        step();
        chk_all("t2_wrap0", 8'h01, 3'd0, 1'b1, 4'd0);
        Request = 8'h00;
        step();
        chk_all("t2_idle", 8'h00, 3'd0, 1'b0, 4'd0);

        // 3: release at beat 1 hands directly to 5, then all drop
        Request = 8'h24;
        step();
        chk_all("t3_own2", 8'h04, 3'd2, 1'b1, 4'd0);
        step();
        chk_all("t3_own2_b1", 8'h04, 3'd2, 1'b1, 4'd1);
        Request = 8'h20;
        step();
        chk_all("t3_hand5", 8'h20, 3'd5, 1'b1, 4'd0);
        Request = 8'h00;
        step();
        chk_all("t3_idle", 8'h00, 3'd5, 1'b0, 4'd0);

        // 4: lone requester keeps the port, count wraps at burst limit
        Request = 8'h08;
        step();
        chk_all("t4_own3", 8'h08, 3'd3, 1'b1, 4'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk_all($sformatf("t4_c%0d", i), 8'h08, 3'd3, 1'b1, 4'(i % 4));
        end
        Request = 8'h00;
        step();
        chk_all("t4_idle", 8'h00, 3'd3, 1'b0, 4'd0);

        // 5: stall at the burst limit blocks handover until Port_Ready
        Request = 8'h10;
        step();
        chk_all("t5_own4", 8'h10, 3'd4, 1'b1, 4'd0);
        step();
        step();
        step();
        chk_all("t5_b3", 8'h10, 3'd4, 1'b1, 4'd3);
        Request    = 8'h11;
        Port_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all($sformatf("t5_stall%0d", i), 8'h10, 3'd4, 1'b1, 4'd3);
        end
        Port_Ready = 1'b1;
        step();
        chk_all("t5_hand0", 8'h01, 3'd0, 1'b1, 4'd0);

        // 6: async reset mid-ownership, then requester 0 wins first
        Request = 8'h40;
        step();
        chk_all("t6_own6", 8'h40, 3'd6, 1'b1, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("t6_async", 8'h00, 3'd0, 1'b0, 4'd0);
        Request = 8'hFF;
        @(negedge clk);
        reset = 1'b1;
        step();
        chk_all("t6_first", 8'h01, 3'd0, 1'b1, 4'd0);
        step();
        chk_all("t6_b1", 8'h01, 3'd0, 1'b1, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
